async_reset_shift_reg_vec: RTL and testbench
============================================

Name: async_reset_shift_reg_vec

Overview:
Parametrised multi-bit, multi-stage shift register whose flops all reset asynchronously to a programmable per-bit value. It generalises the single-bit enable/async-reset register to WIDTH bits and DEPTH stages. It adds a synchronous clear and a "primed" indication that the pipeline holds only post-reset data. It is used for reset-domain-safe delay lines, synchronizer chains and retimed control vectors.

Parameters:
- WIDTH, 1, data bits per stage; legal range >= 1.
- DEPTH, 3, number of stages; legal range >= 1. DEPTH=1 gives a plain enable register.
- RESET_VAL, {WIDTH{1'b0}}, WIDTH-bit value loaded into every stage on rst or clr.

Ports:
- clk  in  1  clock; all state changes on posedge, except rst.
- rst  in  1  reset rst, asynchronous, active-high; deassertion is synchronized externally.
- en  in  1  shift enable.
- clr  in  1  synchronous clear; takes priority over en.
- d  in  WIDTH  data into stage 0.
- q  out  WIDTH  last stage (stage DEPTH-1).
- taps  out  WIDTH*DEPTH  all stages; stage i occupies bits [i*WIDTH +: WIDTH].
- primed  out  1  high once DEPTH enabled shifts have occurred since the last rst or clr.
- fill  out  $clog2(DEPTH+1)  count of enabled shifts since the last rst or clr, saturating at DEPTH.

Behaviour:
- State consists of stage[0..DEPTH-1] (WIDTH bits each) and cnt (fill counter).
- rst asserted (async, immediate, independent of clk):
  - every stage = RESET_VAL; cnt = 0.
  - Therefore q = RESET_VAL, taps = {DEPTH{RESET_VAL}}, primed = 0, fill = 0.
  - Reset holds while rst is high, regardless of en, clr and d.
- Per posedge with rst low, priority is clr > en > hold:
  - clr=1: every stage = RESET_VAL; cnt = 0. The same edge's en and d are discarded.
  - clr=0, en=1: stage[0] = d; stage[i] = stage[i-1] for i = 1..DEPTH-1. cnt = min(cnt+1, DEPTH).
  - clr=0, en=0: all state holds.
- Latency: d captured on enabled edge k appears on q after enabled edge k+DEPTH-1. Stalls (en=0) extend the wall-clock latency but never drop or duplicate data.
- Outputs:
  - q, taps and fill are driven directly from flops, with no combinational path from d, en or clr.
  - primed = (cnt == DEPTH), registered-equivalent since it decodes flop state only.
- Saturation: once cnt = DEPTH, further shifts leave cnt at DEPTH and primed stays 1 until rst or clr.
- Reset mid-operation: an async rst pulse between edges clears all state immediately. The first enabled edge after deassertion loads stage[0] and sets cnt = 1.
- DEPTH=1: q = stage[0], primed rises after the first enabled edge, fill is 1 bit.
- Per-bit RESET_VAL: each bit resets to its own value; bits are not assumed uniform.
- Simulation initial-value randomisation is permitted under the team's standard macros, but only before the first rst. The bench always applies rst first.

Test Plan:
- Reset values: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5. Assert rst async mid-cycle -> q=8'hA5 and taps=24'hA5A5A5 immediately, before the next clk edge; primed=0, fill=0.
- Shift and latency: after rst, en=1 with d=8'h01,8'h02,8'h03 on 3 edges -> q=8'h01 after the 3rd edge; taps=24'h010203 (stage2..0); fill=3, primed=1 from that edge.
- Stall: same config, mid-stream en=0 for 5 cycles -> taps and fill unchanged. Resume with d=8'h04 -> q=8'h02, taps=24'h020304, no loss or duplicate.
- Clear priority: primed=1, then one edge with clr=1, en=1, d=8'hFF -> all stages=8'hA5, fill=0, primed=0, and 8'hFF does not appear in any tap.
- Saturation and async reset mid-stream: 10 enabled shifts -> fill=3, stays 3. Pulse rst for less than one clk period between edges -> q=8'hA5 and fill=0 at once. First edge after release -> fill=1, stage0=d.
- DEPTH=1, WIDTH=1, RESET_VAL=1: rst -> q=1. en=1, d=0 -> q=0 next edge, primed=1. en=0, d=1 -> q holds 0.

Source files
------------

// File: rtl/async_reset_shift_reg_vec.sv
// WIDTH-bit, DEPTH-stage shift register with asynchronous reset to a per-bit
// RESET_VAL, a synchronous clear, and a saturating fill counter with a primed flag.
module async_reset_shift_reg_vec #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic                   primed,
    output logic [CW-1:0]          fill
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = RESET_VAL;
            end
            cnt_d = '0;
        end else if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            // Counter saturates so primed stays high through long runs.
            if (cnt_q != FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
            cnt_q <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_taps
            assign taps[gi*WIDTH +: WIDTH] = stage_q[gi];
        end
    endgenerate

    assign q      = stage_q[DEPTH-1];
    assign fill   = cnt_q;
    assign primed = (cnt_q == FULL);

endmodule

// File: tb/tb_async_reset_shift_reg_vec.sv
// Bench for async_reset_shift_reg_vec: an 8x3 instance (reset value A5) checked
// against a history-queue model, plus a 1x1 instance with reset value 1.
module tb_async_reset_shift_reg_vec;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_a, en_a, clr_a;
    logic [7:0]  d_a, q_a;
    logic [23:0] taps_a;
    logic        primed_a;
    logic [1:0]  fill_a;

    logic        rst_b, en_b, clr_b;
    logic [0:0]  d_b, q_b, taps_b;
    logic        primed_b;
    logic [0:0]  fill_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the last (up to 3) accepted words since the last reset/clear.
    logic [7:0] hist[$];
    int         shifts = 0;

    always #5 clk = ~clk;

    async_reset_shift_reg_vec #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .clr(clr_a), .d(d_a),
        .q(q_a), .taps(taps_a), .primed(primed_a), .fill(fill_a)
    );

    async_reset_shift_reg_vec #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .clr(clr_b), .d(d_b),
        .q(q_b), .taps(taps_b), .primed(primed_b), .fill(fill_b)
    );

    function automatic logic [23:0] exp_taps();
        logic [23:0] r;
        int n;
        n = hist.size();
        for (int i = 0; i < 3; i++) begin
            r[i*8 +: 8] = (i < n) ? hist[n-1-i] : RV;
        end
        return r;
    endfunction

    function automatic void model_clear();
        hist.delete();
        shifts = 0;
    endfunction

    // One clock of instance A; leaves time at posedge+1.
    task automatic step_a(input logic e, input logic c, input logic [7:0] dv);
        en_a = e; clr_a = c; d_a = dv;
        @(posedge clk);
        if (c) begin
            model_clear();
        end else if (e) begin
            hist.push_back(dv);
            if (hist.size() > 3) hist = hist[1:$];
            if (shifts < 3) shifts++;
        end
        #1;
        $display("A: en=%0b clr=%0b d=%02h -> q=%02h taps=%06h fill=%0d primed=%0b",
                 e, c, dv, q_a, taps_a, fill_a, primed_a);
    endtask

    task automatic step_b(input logic e, input logic c, input logic dv);
        en_b = e; clr_b = c; d_b = dv;
        @(posedge clk);
        #1;
        $display("B: en=%0b clr=%0b d=%0b -> q=%0b fill=%0d primed=%0b",
                 e, c, dv, q_b, fill_b, primed_b);
    endtask

    task automatic test_reset();
        step_a(1'b1, 1'b0, 8'h3C);
        step_a(1'b1, 1'b0, 8'hC3);
        #2 rst_a = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (taps_a !== 24'hA5A5A5 || q_a !== RV) begin
            n_fail++;
            $display("FAIL reset_immediate: q=%02h taps=%06h, required q=a5 taps=a5a5a5", q_a, taps_a);
        end
        n_checks++;
        if (fill_a !== 2'd0 || primed_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fill: fill=%0d primed=%0b, required 0/0", fill_a, primed_a);
        end
        // Reset must dominate an enabled edge while held.
        en_a = 1'b1; clr_a = 1'b0; d_a = 8'h77;
        @(posedge clk); #1;
        n_checks++;
        if (taps_a !== 24'hA5A5A5 || fill_a !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: taps=%06h fill=%0d, required a5a5a5/0", taps_a, fill_a);
        end
        en_a = 1'b0;
        #2 rst_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_shift_latency();
        step_a(1'b1, 1'b0, 8'h01);
        step_a(1'b1, 1'b0, 8'h02);
        n_checks++;
        if (primed_a !== 1'b0 || fill_a !== 2'd2 || q_a !== RV) begin
            n_fail++;
            $display("FAIL shift_partial: q=%02h fill=%0d primed=%0b, required a5/2/0", q_a, fill_a, primed_a);
        end
        step_a(1'b1, 1'b0, 8'h03);
        n_checks++;
        if (q_a !== 8'h01 || taps_a !== 24'h010203) begin
            n_fail++;
            $display("FAIL shift_latency: q=%02h taps=%06h, required 01/010203", q_a, taps_a);
        end
        n_checks++;
        if (fill_a !== 2'd3 || primed_a !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_primed: fill=%0d primed=%0b, required 3/1", fill_a, primed_a);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 5; k++) begin
            step_a(1'b0, 1'b0, 8'($urandom));
            n_checks++;
            if (taps_a !== 24'h010203 || fill_a !== 2'd3) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: taps=%06h fill=%0d, required 010203/3", k, taps_a, fill_a);
            end
        end
        step_a(1'b1, 1'b0, 8'h04);
        n_checks++;
        if (q_a !== 8'h02 || taps_a !== 24'h020304) begin
            n_fail++;
            $display("FAIL stall_resume: q=%02h taps=%06h, required 02/020304", q_a, taps_a);
        end
    endtask

    task automatic test_clear_priority();
        step_a(1'b1, 1'b1, 8'hFF);
        n_checks++;
        if (taps_a !== 24'hA5A5A5 || fill_a !== 2'd0 || primed_a !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_priority: taps=%06h fill=%0d primed=%0b, required a5a5a5/0/0",
                     taps_a, fill_a, primed_a);
        end
    endtask

    task automatic test_saturation_async_reset();
        logic [7:0] dv;
        for (int k = 0; k < 10; k++) begin
            step_a(1'b1, 1'b0, 8'($urandom));
            n_checks++;
            if (taps_a !== exp_taps() || fill_a !== 2'(shifts) || primed_a !== (shifts == 3)) begin
                n_fail++;
                $display("FAIL saturate[%0d]: taps=%06h fill=%0d primed=%0b, required %06h/%0d/%0b",
                         k, taps_a, fill_a, primed_a, exp_taps(), shifts, shifts == 3);
            end
        end
        #2 rst_a = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (q_a !== RV || fill_a !== 2'd0 || primed_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset: q=%02h fill=%0d primed=%0b, required a5/0/0", q_a, fill_a, primed_a);
        end
        #2 rst_a = 1'b0;
        dv = 8'($urandom);
        step_a(1'b1, 1'b0, dv);
        n_checks++;
        if (fill_a !== 2'd1 || taps_a !== {RV, RV, dv}) begin
            n_fail++;
            $display("FAIL post_reset_first: taps=%06h fill=%0d, required %06h/1", taps_a, fill_a, {RV, RV, dv});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_a = 1'b1;
                model_clear();
                #2 rst_a = 1'b0;
            end
            step_a(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0), 8'($urandom));
            n_checks++;
            if (taps_a !== exp_taps() || q_a !== exp_taps() >> 16 ||
                fill_a !== 2'(shifts) || primed_a !== (shifts == 3)) begin
                n_fail++;
                $display("FAIL random[%0d]: taps=%06h fill=%0d primed=%0b, required %06h/%0d/%0b",
                         k, taps_a, fill_a, primed_a, exp_taps(), shifts, shifts == 3);
            end
        end
    endtask

    task automatic test_depth1();
        #2 rst_b = 1'b1;
        #1;
        n_checks++;
        if (q_b !== 1'b1 || primed_b !== 1'b0 || fill_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_reset: q=%0b primed=%0b fill=%0d, required 1/0/0", q_b, primed_b, fill_b);
        end
        #2 rst_b = 1'b0;
        step_b(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (q_b !== 1'b0 || primed_b !== 1'b1 || fill_b !== 1'b1 || taps_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_load: q=%0b primed=%0b fill=%0d, required 0/1/1", q_b, primed_b, fill_b);
        end
        step_b(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (q_b !== 1'b0 || primed_b !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_hold: q=%0b primed=%0b, required 0/1", q_b, primed_b);
        end
        step_b(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (q_b !== 1'b1 || primed_b !== 1'b0 || fill_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_clear: q=%0b primed=%0b fill=%0d, required 1/0/0", q_b, primed_b, fill_b);
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; d_a = '0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; d_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_clear();
        test_reset();
        test_shift_latency();
        test_stall();
        test_clear_priority();
        test_saturation_async_reset();
        test_random();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
